sprite_coll_ram: RTL
====================

Name: sprite_coll_ram

Overview:
- Receiving end of the sprite renderer's collision output (sprcoll / sprcoll_ad).
- Latches each reported sprite-sprite collision into a 1024x1 collision RAM and keeps a global summary flag.
- Gives the Z80 side a byte-wide read / write-to-clear port, so the game can tell which sprite pairs overlapped during the frame.
- Sits between the sprite renderer and the CPU address decoder (collision RAM window plus summary register).

Parameters:
- ADDR_W, 10, collision RAM address width; depth is 2**ADDR_W.
- FIFO_DEPTH, 4, pending-set queue entries; must be a power of 2.

Ports:
- VCLKx8  in  1  system video clock.
- RST_N  in  1  asynchronous active-low reset.
- VCLKx4_EN  in  1  renderer step enable; sprcoll is sampled only when this is high.
- sprcoll  in  1  collision strobe from the sprite renderer.
- sprcoll_ad  in  ADDR_W  collision entry address, {sprite[4:0], other sprite[4:0]}.
- CPUAD  in  ADDR_W  CPU entry address.
- CPUCS_RAM  in  1  one-cycle access strobe, collision RAM window.
- CPUCS_SUM  in  1  one-cycle access strobe, summary register.
- CPUWR  in  1  1 = write (clear), 0 = read; qualified by a strobe.
- CPUDO  out  8  read data.
- CPURDY  out  1  high once the init sweep is complete.
- collflag  out  1  summary flag: any collision committed since the last clear.
- ovf  out  1  sticky flag: a set was dropped because the FIFO was full.

Behaviour:
- Async reset (RST_N low) values: CPUDO=8'hFF, CPURDY=0, collflag=0, ovf=0, FIFO empty, state=INIT, sweep counter=0. RAM contents are not reset asynchronously.
- All logic runs on posedge VCLKx8.

State machine:
- INIT: writes 0 to RAM[cnt] each cycle, cnt++. When cnt == 2**ADDR_W-1 is written, go to RUN and set CPURDY=1. The sweep takes exactly 1024 cycles.
- In INIT, CPU strobes are ignored (CPUDO unchanged) and collision sets are enqueued but not drained.
- RUN: steady state. There is no return to INIT except via reset. Reset asserted mid-sweep or mid-run restarts INIT from 0.

Capture:
- Push sprcoll_ad into the FIFO when VCLKx4_EN && sprcoll.
- If the FIFO is full, drop the entry and set ovf=1.

Single RAM port arbitration, one operation per cycle, priority order:
1. INIT sweep.
2. CPU strobe.
3. FIFO drain.

Operations in RUN:
- CPU read, RAM window (CPUCS_RAM && !CPUWR): CPUDO <= {7'b1111111, RAM[CPUAD]} on the next edge, so data is valid 1 cycle after the strobe and held until the next read.
- CPU write, RAM window (CPUCS_RAM && CPUWR): RAM[CPUAD] <= 0. The write data bus is ignored, since any write clears.
- CPU read, summary (CPUCS_SUM && !CPUWR): CPUDO <= {6'b111111, ovf, collflag}, 1-cycle latency.
- CPU write, summary (CPUCS_SUM && CPUWR): collflag <= 0 and ovf <= 0.
- Both CPUCS_RAM and CPUCS_SUM asserted: CPUCS_RAM wins; the summary access is ignored.
- Drain, in a cycle with no CPU strobe and a non-empty FIFO: RAM[head] <= 1, collflag <= 1, pop.

Ordering and simultaneous events:
- Effects are applied in arrival order. A CPU clear of entry X with a set of X still queued leaves X = 1 after the drain.
- A set pending in the FIFO does not affect collflag until it is committed. A summary clear followed by a later drain sets collflag again.
- Push and pop in the same cycle are allowed when the FIFO is full: the pop frees the slot, the push succeeds, and ovf is not set.
- A push with the FIFO full and no pop drops the entry.
- FIFO pointers are ADDR_W-independent, log2(FIFO_DEPTH)+1 bits with wrap-bit full/empty detection.

Decomposition:
- Shared package sys1_coll_pkg holds:
  - constants COLL_ADDR_W=10 and COLL_FIFO_DEPTH=4;
  - read pad constants RAM_RD_PAD=7'h7F and SUM_RD_PAD=6'h3F;
  - state enum {ST_INIT, ST_RUN}.
- One sub-module, coll_fifo: a synchronous FIFO with push/pop, full/empty and async active-low reset.
- The RAM stays an inferred array inside sprite_coll_ram.

Test Plan:
- Reset, then idle: CPURDY rises exactly 1024 cycles after RST_N deasserts. Reading RAM at 10'h000, 10'h3FF and 10'h155 returns 8'hFE; reading the summary returns 8'hFC.
- Single collision: sprcoll=1 with sprcoll_ad=10'h0A3 on one VCLKx4_EN cycle, then idle. RAM[0x0A3] reads 8'hFF, collflag=1, and RAM[0x0A2] reads 8'hFE.
- Clear ordering: with 0x0A3 set, write CPUCS_RAM to 0x0A3, then read it back: 8'hFE. A set of 0x0A3 enqueued while the CPU is clearing 0x0A3 ends with a read of 8'hFF.
- CPU starvation and overflow: hold CPU strobes every cycle while 5 sets arrive (0x001..0x005). Then ovf=1, addresses 0x001..0x004 read 8'hFF, and 0x005 reads 8'hFE.
- Summary clear: write CPUCS_SUM, so collflag=0 and ovf=0 and the summary reads 8'hFC. A subsequent set returns collflag to 1.
- Reset mid-operation: assert RST_N low for 1 cycle during RUN with FIFO entries pending. CPURDY=0, collflag=0 and the FIFO is empty; after the new 1024-cycle sweep, all entries read 8'hFE.

Source files
------------

// File: rtl/sprite_coll_ram_pkg.sv
// Shared constants and state type for the sprite collision RAM and its bus interface.
package sys1_coll_pkg;

    localparam int COLL_ADDR_W     = 10;
    localparam int COLL_FIFO_DEPTH = 4;

    // Unused upper bits of CPUDO read back as ones.
    localparam logic [6:0] RAM_RD_PAD = 7'h7F;
    localparam logic [5:0] SUM_RD_PAD = 6'h3F;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } coll_state_e;

endpackage

// File: rtl/sprite_coll_ram_if.sv
// Renderer collision strobe and Z80 collision-window bus, plus status/debug outputs.
interface sprite_coll_ram_if
    import sys1_coll_pkg::*;
#(
    parameter int ADDR_W = COLL_ADDR_W
);
    // Single-cycle strobes, no handshake: sprcoll counts only when VCLKx4_EN is high,
    // CPUCS_RAM/CPUCS_SUM are one-cycle accesses honoured only while CPURDY is high,
    // and read data appears on CPUDO one cycle after the strobe and holds until the next read.
    logic              VCLKx4_EN;
    logic              sprcoll;
    logic [ADDR_W-1:0] sprcoll_ad;
    logic [ADDR_W-1:0] CPUAD;
    logic              CPUCS_RAM;
    logic              CPUCS_SUM;
    logic              CPUWR;
    logic [7:0]        CPUDO;
    logic              CPURDY;
    logic              collflag;
    logic              ovf;
    coll_state_e       state_dbg;

    modport master (
        output VCLKx4_EN, sprcoll, sprcoll_ad, CPUAD, CPUCS_RAM, CPUCS_SUM, CPUWR,
        input  CPUDO, CPURDY, collflag, ovf, state_dbg
    );

    modport slave (
        input  VCLKx4_EN, sprcoll, sprcoll_ad, CPUAD, CPUCS_RAM, CPUCS_SUM, CPUWR,
        output CPUDO, CPURDY, collflag, ovf, state_dbg
    );

endinterface

// File: rtl/sprite_coll_ram_coll_fifo.sv
// Small synchronous FIFO holding collision sets until the RAM port is free.
module coll_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW:0]  wr_q, wr_d, rd_q, rd_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         push_ok, pop_ok;

    // Extra wrap bit on each pointer separates full from empty.
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
    assign rd_d    = pop_ok ? rd_q + 1'b1 : rd_q;
    assign dout_o  = mem_q[rd_q[PW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_q[PW-1:0]] <= din_i;
    end

endmodule

// File: rtl/sprite_coll_ram.sv
// Collision RAM: latches renderer sprite-pair collisions, exposes them to the CPU
// as read / write-to-clear bits plus a summary register.
module sprite_coll_ram
    import sys1_coll_pkg::*;
#(
    parameter int ADDR_W     = COLL_ADDR_W,
    parameter int FIFO_DEPTH = COLL_FIFO_DEPTH
) (
    input  logic             VCLKx8,
    input  logic             RST_N,
    sprite_coll_ram_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    coll_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [7:0]        cpudo_q, cpudo_d;
    logic              collflag_q, collflag_d;
    logic              ovf_q, ovf_d;

    logic              ram_q [DEPTH];
    logic              ram_we, ram_wd;
    logic [ADDR_W-1:0] ram_wa;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ADDR_W-1:0] fifo_head;

    assign fifo_push = bus.VCLKx4_EN & bus.sprcoll;

    coll_fifo #(.W(ADDR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (VCLKx8),
        .rst_ni  (RST_N),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (bus.sprcoll_ad),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // One RAM operation per cycle: init sweep, then CPU, then FIFO drain.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cpudo_d    = cpudo_q;
        collflag_d = collflag_q;
        ovf_d      = ovf_q;
        ram_we     = 1'b0;
        ram_wa     = cnt_q;
        ram_wd     = 1'b0;
        fifo_pop   = 1'b0;
        case (state_q)
            ST_INIT: begin
                ram_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (&cnt_q) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.CPUCS_RAM) begin
                    if (bus.CPUWR) begin
                        ram_we = 1'b1;
                        ram_wa = bus.CPUAD;
                    end else begin
                        cpudo_d = {RAM_RD_PAD, ram_q[bus.CPUAD]};
                    end
                end else if (bus.CPUCS_SUM) begin
                    if (bus.CPUWR) begin
                        collflag_d = 1'b0;
                        ovf_d      = 1'b0;
                    end else begin
                        cpudo_d = {SUM_RD_PAD, ovf_q, collflag_q};
                    end
                end else if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    ram_we     = 1'b1;
                    ram_wa     = fifo_head;
                    ram_wd     = 1'b1;
                    collflag_d = 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase
        // A drop in the same cycle as a summary clear is the later event and survives it.
        if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
    end

    always_ff @(posedge VCLKx8 or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            cpudo_q    <= 8'hFF;
            collflag_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cpudo_q    <= cpudo_d;
            collflag_q <= collflag_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge VCLKx8) begin
        if (ram_we) ram_q[ram_wa] <= ram_wd;
    end

    assign bus.CPUDO     = cpudo_q;
    assign bus.CPURDY    = (state_q == ST_RUN);
    assign bus.collflag  = collflag_q;
    assign bus.ovf       = ovf_q;
    assign bus.state_dbg = state_q;

endmodule
